// File: rtl/vector_dot_seq.sv
// Master-side sequencer: streams operand pairs from RAM into the vector_dot slave.
// Optional macro VDOT_SEQ_SKIP_ZERO_EN skips slave writes for pairs with a +/-0.0 operand.
module vector_dot_seq #(
    parameter int ADDR_W       = 8,
    parameter int LEN_W        = 7,
    parameter int GAP_CYCLES   = 0,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dp_address,
    output logic [31:0]       dp_writedata,
    output logic              dp_write,
    output logic              dp_read,
    input  logic [31:0]       dp_readdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_CAPB,
        S_WRA,
        S_WRB,
        S_GAP,
        S_TERM,
        S_RD,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO = ADDR_W'(2);
    localparam logic [LEN_W-1:0]  L_ONE = LEN_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [3:0]        gcnt;
    logic [1:0]        wcnt;

    logic [ADDR_W-1:0] addr_nx;
    logic [LEN_W-1:0]  cnt_nx;
    logic              more_nx;
    logic              more_now;

    assign addr_nx  = addr + A_TWO;
    assign cnt_nx   = cnt + L_ONE;
    assign more_nx  = (cnt_nx != len_q);
    assign more_now = (cnt != len_q);

`ifdef VDOT_SEQ_SKIP_ZERO_EN
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction
`endif

    // Outputs are registered: each transition loads the strobes of the state entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            len_q        <= '0;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            gcnt         <= '0;
            wcnt         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            dp_address   <= '0;
            dp_writedata <= '0;
            dp_write     <= 1'b0;
            dp_read      <= 1'b0;
        end else begin
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            dp_write     <= 1'b0;
            dp_read      <= 1'b0;
            dp_address   <= '0;
            dp_writedata <= '0;
            done         <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        addr   <= base;
                        len_q  <= length;
                        cnt    <= '0;
                        result <= '0;
                        busy   <= 1'b1;
                        if (length == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_RDA;
                            mem_rd   <= 1'b1;
                            mem_addr <= base;
                        end
                    end
                end
                S_RDA: begin
                    state    <= S_RDB;
                    mem_rd   <= 1'b1;
                    mem_addr <= addr + A_ONE;
                end
                S_RDB: begin
                    a_q   <= mem_rdata;
                    state <= S_CAPB;
                end
                S_CAPB: begin
                    b_q <= mem_rdata;
`ifdef VDOT_SEQ_SKIP_ZERO_EN
                    if (is_zero(a_q) || is_zero(mem_rdata)) begin
                        addr <= addr_nx;
                        cnt  <= cnt_nx;
                        if (more_nx) begin
                            state    <= S_RDA;
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_nx;
                        end else begin
                            state    <= S_TERM;
                            dp_write <= 1'b1;
                        end
                    end else begin
                        state        <= S_WRA;
                        dp_write     <= 1'b1;
                        dp_writedata <= a_q;
                    end
`else
                    state        <= S_WRA;
                    dp_write     <= 1'b1;
                    dp_writedata <= a_q;
`endif
                end
                S_WRA: begin
                    state        <= S_WRB;
                    dp_write     <= 1'b1;
                    dp_address   <= 2'd1;
                    dp_writedata <= b_q;
                end
                S_WRB: begin
                    addr <= addr_nx;
                    cnt  <= cnt_nx;
                    if (GAP_CYCLES > 0) begin
                        state <= S_GAP;
                        gcnt  <= 4'(GAP_CYCLES - 1);
                    end else if (more_nx) begin
                        state    <= S_RDA;
                        mem_rd   <= 1'b1;
                        mem_addr <= addr_nx;
                    end else begin
                        state    <= S_TERM;
                        dp_write <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt != 4'd0) begin
                        gcnt <= gcnt - 4'd1;
                    end else if (more_now) begin
                        state    <= S_RDA;
                        mem_rd   <= 1'b1;
                        mem_addr <= addr;
                    end else begin
                        state    <= S_TERM;
                        dp_write <= 1'b1;
                    end
                end
                S_TERM: begin
                    state   <= S_RD;
                    dp_read <= 1'b1;
                end
                S_RD: begin
                    if (READ_LATENCY == 0) begin
                        result <= dp_readdata;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wcnt  <= 2'(READ_LATENCY - 1);
                        state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (wcnt == 2'd0) begin
                        result <= dp_readdata;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                S_DONE: begin
                    // Zero-length runs arrive still busy: pulse done one cycle later.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_dot_seq.sv
// Scoreboard bench for vector_dot_seq: u0 runs GAP=0/RL=0, u1 runs GAP=2/RL=2.
module tb_vector_dot_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [256];
    logic [31:0] slave_val;

    logic        start0, busy0, done0, mem_rd0, dp_write0, dp_read0;
    logic [7:0]  base0, mem_addr0;
    logic [6:0]  length0;
    logic [31:0] result0, mem_rdata0, dp_writedata0, dp_readdata0;
    logic [1:0]  dp_address0;

    logic        start1, busy1, done1, mem_rd1, dp_write1, dp_read1;
    logic [7:0]  base1, mem_addr1;
    logic [6:0]  length1;
    logic [31:0] result1, mem_rdata1, dp_writedata1, dp_readdata1;
    logic [1:0]  dp_address1;

    vector_dot_seq #(.ADDR_W(8), .LEN_W(7), .GAP_CYCLES(0), .READ_LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .base(base0), .length(length0),
        .busy(busy0), .done(done0), .result(result0), .mem_addr(mem_addr0),
        .mem_rd(mem_rd0), .mem_rdata(mem_rdata0), .dp_address(dp_address0),
        .dp_writedata(dp_writedata0), .dp_write(dp_write0), .dp_read(dp_read0),
        .dp_readdata(dp_readdata0)
    );

    vector_dot_seq #(.ADDR_W(8), .LEN_W(7), .GAP_CYCLES(2), .READ_LATENCY(2)) u1 (
        .clk(clk), .reset(reset), .start(start1), .base(base1), .length(length1),
        .busy(busy1), .done(done1), .result(result1), .mem_addr(mem_addr1),
        .mem_rd(mem_rd1), .mem_rdata(mem_rdata1), .dp_address(dp_address1),
        .dp_writedata(dp_writedata1), .dp_write(dp_write1), .dp_read(dp_read1),
        .dp_readdata(dp_readdata1)
    );

    always @(posedge clk) begin
        if (mem_rd0) mem_rdata0 <= ram[mem_addr0];
        if (mem_rd1) mem_rdata1 <= ram[mem_addr1];
    end

    // Slave model: read data is only valid in the latency-matched cycle.
    logic [1:0] rpipe1;
    always @(posedge clk or posedge reset) begin
        if (reset) rpipe1 <= 2'b00;
        else rpipe1 <= {rpipe1[0], dp_read1};
    end
    assign dp_readdata0 = dp_read0 ? slave_val : 32'hDEADBEEF;
    assign dp_readdata1 = rpipe1[1] ? slave_val : 32'hDEADBEEF;

    typedef struct {
        logic [31:0] res;
        int busy;
        int reads;
    } exp_t;

    logic [7:0]  maq0[$];
    logic [33:0] wq0[$];
    exp_t        rq0[$];
    logic [33:0] wq1[$];
    exp_t        rq1[$];

    int busy_cnt0 = 0, reads0 = 0, done_cnt0 = 0;
    int busy_cnt1 = 0, reads1 = 0, done_cnt1 = 0;
    logic prev_busy0 = 1'b0, prev_busy1 = 1'b0;
    logic [7:0]  ea0;
    logic [33:0] ew0, ew1;
    exp_t        er0, er1;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt0 = 0; reads0 = 0; prev_busy0 = 1'b0;
        end else begin
            if (mem_rd0) begin
                checks++;
                if (maq0.size() == 0) begin
                    failures++;
                    $display("FAIL u0_mem_rd unexpected got_addr=%0d", mem_addr0);
                end else begin
                    ea0 = maq0.pop_front();
                    if (mem_addr0 !== ea0) begin
                        failures++;
                        $display("FAIL u0_mem_addr got=%0d exp=%0d", mem_addr0, ea0);
                    end
                end
            end
            if (dp_write0) begin
                checks++;
                if (wq0.size() == 0) begin
                    failures++;
                    $display("FAIL u0_dp_write unexpected got=%0d,%h", dp_address0, dp_writedata0);
                end else begin
                    ew0 = wq0.pop_front();
                    if ({dp_address0, dp_writedata0} !== ew0) begin
                        failures++;
                        $display("FAIL u0_dp_write got=%0d,%h exp=%0d,%h",
                                 dp_address0, dp_writedata0, ew0[33:32], ew0[31:0]);
                    end
                end
            end
            if (dp_read0) reads0++;
            checks++;
            if ((dp_write0 && dp_read0) ||
                (!dp_write0 && !dp_read0 && (dp_address0 != 2'd0 || dp_writedata0 != 32'd0))) begin
                failures++;
                $display("FAIL u0_strobe_rule got wr=%b rd=%b a=%0d d=%h exp idle zeros",
                         dp_write0, dp_read0, dp_address0, dp_writedata0);
            end
            if (done0) begin
                checks++;
                if (rq0.size() == 0) begin
                    failures++;
                    $display("FAIL u0_done unexpected result=%h", result0);
                end else begin
                    er0 = rq0.pop_front();
                    if (result0 !== er0.res || busy_cnt0 != er0.busy || reads0 != er0.reads ||
                        busy0 !== 1'b0 || !prev_busy0) begin
                        failures++;
                        $display("FAIL u0_done got res=%h busy=%0d reads=%0d exp res=%h busy=%0d reads=%0d",
                                 result0, busy_cnt0, reads0, er0.res, er0.busy, er0.reads);
                    end
                end
                busy_cnt0 = 0; reads0 = 0; done_cnt0++;
            end
            if (busy0) busy_cnt0++;
            prev_busy0 = busy0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt1 = 0; reads1 = 0; prev_busy1 = 1'b0;
        end else begin
            if (dp_write1) begin
                checks++;
                if (wq1.size() == 0) begin
                    failures++;
                    $display("FAIL u1_dp_write unexpected got=%0d,%h", dp_address1, dp_writedata1);
                end else begin
                    ew1 = wq1.pop_front();
                    if ({dp_address1, dp_writedata1} !== ew1) begin
                        failures++;
                        $display("FAIL u1_dp_write got=%0d,%h exp=%0d,%h",
                                 dp_address1, dp_writedata1, ew1[33:32], ew1[31:0]);
                    end
                end
            end
            if (dp_read1) reads1++;
            if (done1) begin
                checks++;
                if (rq1.size() == 0) begin
                    failures++;
                    $display("FAIL u1_done unexpected result=%h", result1);
                end else begin
                    er1 = rq1.pop_front();
                    if (result1 !== er1.res || busy_cnt1 != er1.busy || reads1 != er1.reads ||
                        busy1 !== 1'b0 || !prev_busy1) begin
                        failures++;
                        $display("FAIL u1_done got res=%h busy=%0d reads=%0d exp res=%h busy=%0d reads=%0d",
                                 result1, busy_cnt1, reads1, er1.res, er1.busy, er1.reads);
                    end
                end
                busy_cnt1 = 0; reads1 = 0; done_cnt1++;
            end
            if (busy1) busy_cnt1++;
            prev_busy1 = busy1;
        end
    end

    task automatic pw0(input logic [1:0] a, input logic [31:0] d);
        wq0.push_back({a, d});
    endtask

    task automatic pw1(input logic [1:0] a, input logic [31:0] d);
        wq1.push_back({a, d});
    endtask

    task automatic pm0(input int first, input int n);
        for (int i = 0; i < n; i++) maq0.push_back(8'(first + i));
    endtask

    task automatic pr0(input logic [31:0] r, input int b, input int rd);
        exp_t e;
        e.res = r; e.busy = b; e.reads = rd;
        rq0.push_back(e);
    endtask

    task automatic kick0(input logic [7:0] b, input logic [6:0] l);
        @(posedge clk); #1;
        start0 = 1'b1; base0 = b; length0 = l;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string name, input int budget);
        int d, n;
        d = done_cnt0; n = 0;
        while (done_cnt0 == d && n < budget) begin
            @(posedge clk); n++;
        end
        #1;
        if (done_cnt0 == d) begin
            checks++; failures++;
            $display("FAIL %s timeout got no done exp done within %0d cycles", name, budget);
        end
    endtask

    task automatic drain0(input string name);
        checks++;
        if (maq0.size() != 0 || wq0.size() != 0 || rq0.size() != 0) begin
            failures++;
            $display("FAIL %s leftover got mem=%0d wr=%0d res=%0d exp 0 0 0",
                     name, maq0.size(), wq0.size(), rq0.size());
        end
        maq0.delete(); wq0.delete(); rq0.delete();
    endtask

    task automatic zero0(input string name);
        checks++;
        if ({busy0, done0, result0, mem_addr0, mem_rd0, dp_address0,
             dp_writedata0, dp_write0, dp_read0} !== '0) begin
            failures++;
            $display("FAIL %s got busy=%b done=%b res=%h maddr=%0d mrd=%b a=%0d d=%h wr=%b rd=%b exp all 0",
                     name, busy0, done0, result0, mem_addr0, mem_rd0,
                     dp_address0, dp_writedata0, dp_write0, dp_read0);
        end
    endtask

    task automatic exp_t1();
        pm0(0, 6);
        pw0(2'd0, 32'h3F800000); pw0(2'd1, 32'h40000000);
        pw0(2'd0, 32'h40400000); pw0(2'd1, 32'h40800000);
        pw0(2'd0, 32'h40A00000); pw0(2'd1, 32'h40C00000);
        pw0(2'd0, 32'h00000000);
        pr0(32'h42300000, 17, 1);
    endtask

    initial begin
        int n, seen;
        reset = 1'b1;
        start0 = 1'b0; base0 = '0; length0 = '0;
        start1 = 1'b0; base1 = '0; length1 = '0;
        slave_val = 32'h0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[0] = 32'h3F800000; ram[1] = 32'h40000000;
        ram[2] = 32'h40400000; ram[3] = 32'h40800000;
        ram[4] = 32'h40A00000; ram[5] = 32'h40C00000;
        ram[255] = 32'h40E00000;
        ram[16] = 32'h3F800000; ram[17] = 32'h40000000;
        ram[18] = 32'h00000000; ram[19] = 32'h40400000;
        ram[20] = 32'h40A00000; ram[21] = 32'h40C00000;
        repeat (3) @(posedge clk);
        #1;
        zero0("reset_state");
        reset = 1'b0;

        // basic three-pair run
        slave_val = 32'h42300000;
        exp_t1();
        kick0(8'd0, 7'd3);
        wait_done0("t1_basic", 60);
        drain0("t1_basic");

        // zero length
        pr0(32'h0, 1, 0);
        kick0(8'd0, 7'd0);
        wait_done0("t2_len0", 20);
        drain0("t2_len0");

        // base wraps past the top of the RAM
        slave_val = 32'h40E00000;
        maq0.push_back(8'd255); maq0.push_back(8'd0);
        pw0(2'd0, 32'h40E00000); pw0(2'd1, 32'h3F800000); pw0(2'd0, 32'h0);
        pr0(32'h40E00000, 7, 1);
        kick0(8'd255, 7'd1);
        wait_done0("t3_wrap", 30);
        drain0("t3_wrap");

        // start while busy and coincident with done is ignored
        slave_val = 32'h42300000;
        exp_t1();
        kick0(8'd0, 7'd3);
        repeat (4) @(posedge clk);
        #1;
        start0 = 1'b1; base0 = 8'h40; length0 = 7'd5;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; base0 = '0; length0 = '0;
        checks++;
        if (busy0 !== 1'b0 || mem_rd0 !== 1'b0 || n >= 60) begin
            failures++;
            $display("FAIL t4_start_at_done got busy=%b mem_rd=%b wait=%0d exp 0 0 <60", busy0, mem_rd0, n);
        end
        repeat (3) @(posedge clk);
        #1;
        drain0("t4_ignore");

        // reset in WRB of pair 1 aborts that write
        pm0(0, 4);
        pw0(2'd0, 32'h3F800000); pw0(2'd1, 32'h40000000); pw0(2'd0, 32'h40400000);
        kick0(8'd0, 7'd3);
        n = 0; seen = 0;
        while (seen < 2 && n < 40) begin
            @(posedge clk); #1; n++;
            if (dp_write0 && dp_address0 == 2'd1) seen++;
        end
        #2;
        reset = 1'b1;
        @(negedge clk); #1;
        zero0("t5_reset_async");
        @(posedge clk); #1;
        zero0("t5_reset_next");
        reset = 1'b0;
        drain0("t5_reset");
        exp_t1();
        kick0(8'd0, 7'd3);
        wait_done0("t5_clean", 60);
        drain0("t5_clean");

        // gap and read latency
        slave_val = 32'h3F000000;
        pw1(2'd0, 32'h3F800000); pw1(2'd1, 32'h40000000);
        pw1(2'd0, 32'h40400000); pw1(2'd1, 32'h40800000);
        pw1(2'd0, 32'h40A00000); pw1(2'd1, 32'h40C00000);
        pw1(2'd0, 32'h00000000);
        begin
            exp_t e;
            e.res = 32'h3F000000; e.busy = 25; e.reads = 1;
            rq1.push_back(e);
        end
        @(posedge clk); #1;
        start1 = 1'b1; base1 = 8'd0; length1 = 7'd3;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (done_cnt1 == 0 && n < 80) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (done_cnt1 != 1 || wq1.size() != 0 || rq1.size() != 0) begin
            failures++;
            $display("FAIL t6_gap_rl got done=%0d wr_left=%0d res_left=%0d exp 1 0 0",
                     done_cnt1, wq1.size(), rq1.size());
        end

        // zero operand in pair 1
        slave_val = 32'h41F00000;
        pm0(16, 6);
        pw0(2'd0, 32'h3F800000); pw0(2'd1, 32'h40000000);
`ifdef VDOT_SEQ_SKIP_ZERO_EN
        pr0(32'h41F00000, 15, 1);
`else
        pw0(2'd0, 32'h00000000); pw0(2'd1, 32'h40400000);
        pr0(32'h41F00000, 17, 1);
`endif
        pw0(2'd0, 32'h40A00000); pw0(2'd1, 32'h40C00000);
        pw0(2'd0, 32'h00000000);
        kick0(8'd16, 7'd3);
        wait_done0("t7_zero", 60);
        drain0("t7_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
